// File: rtl/rf_wb_scheduler_pkg.sv
// Shared core types for the writeback scheduler: register-file geometry,
// address/data types and a one-hot register mask helper.
package rf_wb_scheduler_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  // One-hot mask selecting register a inside an NREG-wide bit vector.
  function automatic logic [NREG-1:0] reg_mask(input reg_addr_t a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of the decode-issue, writeback-requester and register-file write
// signals owned by the scheduler. The slave side is the scheduler itself.
interface rf_wb_scheduler_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
);

  // decode issue port
  logic                               issue_valid;
  rf_wb_scheduler_pkg::reg_addr_t     issue_rd;
  logic                               issue_wr;
  rf_wb_scheduler_pkg::reg_addr_t     rs1;
  rf_wb_scheduler_pkg::reg_addr_t     rs2;
  logic                               issue_stall;

  // writeback requesters
  logic [NREQ-1:0]                    req_valid;
  logic [NREQ-1:0][4:0]               req_rd;
  logic [NREQ-1:0][XLEN-1:0]          req_data;
  logic [NREQ-1:0]                    req_ready;

  // register file write port
  logic                               we3;
  rf_wb_scheduler_pkg::reg_addr_t     a3;
  logic [XLEN-1:0]                    wd3;
  logic                               wb_err;

  modport master (
    output issue_valid, issue_rd, issue_wr, rs1, rs2,
    output req_valid, req_rd, req_data,
    input  issue_stall, req_ready, we3, a3, wd3, wb_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wr, rs1, rs2,
    input  req_valid, req_rd, req_data,
    output issue_stall, req_ready, we3, a3, wd3, wb_err
  );

endinterface

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from rr_ptr;
// the pointer moves past the winner only when the consumer signals adv.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_nxt;

  // First requester at or after rr_ptr wins; remember where to resume.
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    ptr_nxt = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer only advances on a consumed grant; idle cycles hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rr_ptr <= '0;
    else if (adv) rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the register file's single write port:
// round-robin grant of writeback requesters, a one-cycle registered write
// stage, and a busy-bit scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  rf_wb_scheduler_if.slave  bus
);

  import rf_wb_scheduler_pkg::*;

  logic [NREQ-1:0] gnt;
  logic            grant_any;
  reg_addr_t       g_rd;
  logic [XLEN-1:0] g_data;
  logic            wr_go;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            issue_acc;

  logic            we3_q;
  reg_addr_t       a3_q;
  logic [XLEN-1:0] wd3_q;
  logic            err_q;

  // Grants depend only on req_valid and the arbiter pointer.
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .adv (grant_any),
    .gnt (gnt)
  );

  assign grant_any     = |gnt;
  assign bus.req_ready = gnt;

  // Mux the winning requester's payload; gnt is one-hot so OR is enough.
  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_rd   = g_rd | bus.req_rd[i];
        g_data = g_data | bus.req_data[i];
      end
    end
  end

  // A grant to x0 is consumed but never reaches the register file.
  assign wr_go = grant_any && (g_rd != '0);

  // Hazard check against pending writes; no bypass from the commit cycle.
  assign bus.issue_stall = bus.issue_valid &
                           (busy[bus.rs1] | busy[bus.rs2] |
                            (bus.issue_wr & busy[bus.issue_rd]));
  assign issue_acc = bus.issue_valid & ~bus.issue_stall;

  // Release the committing register, reserve the newly issued one; x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (we3_q)
      busy_nxt = busy_nxt & ~reg_mask(a3_q);
    if (issue_acc && bus.issue_wr && (bus.issue_rd != '0))
      busy_nxt = busy_nxt | reg_mask(bus.issue_rd);
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Write stage: a grant at edge N drives the register file during cycle N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= wr_go;
      if (wr_go) begin
        a3_q  <= g_rd;
        wd3_q <= g_data;
      end
    end
  end

  // Sticky flag: a writeback arrived for a register nobody reserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     err_q <= 1'b0;
    else if (wr_go && !busy[g_rd]) err_q <= 1'b1;
  end

  assign bus.we3    = we3_q;
  assign bus.a3     = a3_q;
  assign bus.wd3    = wd3_q;
  assign bus.wb_err = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench: a reference model predicts grants, stalls and the
// error flag each cycle; expected register-file writes are queued at grant
// time and popped when the write stage should drive them.
module tb_rf_wb_scheduler;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;

  rf_wb_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN)) bus();

  rf_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t         wq[$];
  logic [31:0] mbusy;
  int          mptr;
  logic        merr;
  int          last_g;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mbusy  = '0;
    mptr   = 0;
    merr   = 1'b0;
    last_g = -1;
    wq.delete();
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_wr    = 1'b0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.req_valid   = '0;
    bus.req_rd      = '0;
    bus.req_data    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, cross the edge, advance the model.
  task automatic cyc();
    int              g;
    int              idx;
    logic            st;
    logic [NREQ-1:0] er;
    wb_t             e;
    logic            cm;
    logic [4:0]      crd;
    logic [31:0]     ob;
    logic [4:0]      grd;
    #3;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    st = bus.issue_valid & (mbusy[bus.rs1] | mbusy[bus.rs2] |
                            (bus.issue_wr & mbusy[bus.issue_rd]));
    chk("issue_stall", bus.issue_stall, st);
    cm  = 1'b0;
    crd = '0;
    if (wq.size() > 0) begin
      e   = wq.pop_front();
      cm  = 1'b1;
      crd = e.rd;
      chk("we3", bus.we3, 1);
      chk("a3", bus.a3, e.rd);
      chk("wd3", bus.wd3, e.data);
    end else begin
      chk("we3_idle", bus.we3, 0);
    end
    chk("wb_err", bus.wb_err, merr);
    ob = mbusy;
    @(posedge clk); #1;
    if (cm) mbusy[crd] = 1'b0;
    if (bus.issue_valid && !st && bus.issue_wr && bus.issue_rd != 0)
      mbusy[bus.issue_rd] = 1'b1;
    last_g = g;
    if (g >= 0) begin
      mptr = (g + 1) % NREQ;
      grd  = bus.req_rd[g];
      if (grd != 0) begin
        if (!ob[grd]) merr = 1'b1;
        wq.push_back(wb_t'{grd, bus.req_data[g]});
      end
      bus.req_valid[g] = 1'b0;
    end
  endtask

  initial begin
    int sl[NREQ];

    // 1. reset state with all inputs low
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #3;
    chk("rst_we3", bus.we3, 0);
    chk("rst_stall", bus.issue_stall, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_err", bus.wb_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2. RAW on rd=5, released only after the commit cycle
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd5;
    cyc();
    bus.issue_wr = 1'b0; bus.issue_rd = 5'd0; bus.rs1 = 5'd5;
    cyc();
    bus.req_valid[0] = 1'b1; bus.req_rd[0] = 5'd5; bus.req_data[0] = 32'hDEADBEEF;
    cyc();
    cyc();
    cyc();
    bus.issue_valid = 1'b0; bus.rs1 = '0;

    // 3. all requesters valid for 6 cycles -> 0,1,2,0,1,2
    do_reset();
    for (int r = 10; r < 16; r++) begin
      bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'(r);
      cyc();
    end
    bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.issue_rd = '0;
    for (int i = 0; i < NREQ; i++) sl[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[i] = 1'b1;
        bus.req_rd[i]    = 5'(10 + i + 3 * sl[i]);
        bus.req_data[i]  = 32'(32'hA000 + c * 16 + i);
      end
      cyc();
      chk("rr_order", 64'(last_g), 64'(c % NREQ));
      chk("one_hot_cnt", 64'(last_g >= 0), 1);
      if (last_g >= 0) sl[last_g]++;
    end
    bus.req_valid = '0;
    cyc();

    // 4. x0 never stalls and never writes
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd0;
    cyc();
    bus.issue_wr = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    cyc();
    bus.issue_valid = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_rd[1] = 5'd0; bus.req_data[1] = 32'h1234;
    cyc();
    cyc();

    // 5. WAW stall, then set/clear of different registers on one edge
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd7;
    cyc();
    cyc();
    bus.issue_rd = 5'd3;
    cyc();
    bus.issue_valid = 1'b0;
    bus.req_valid[2] = 1'b1; bus.req_rd[2] = 5'd3; bus.req_data[2] = 32'h3333_0003;
    cyc();
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd9;
    cyc();
    bus.issue_wr = 1'b0; bus.issue_rd = 5'd0; bus.rs1 = 5'd3;
    cyc();
    bus.rs1 = 5'd9;
    cyc();
    bus.issue_valid = 1'b0; bus.rs1 = '0;

    // 6. writeback to a non-busy register sets the sticky error
    bus.req_valid[0] = 1'b1; bus.req_rd[0] = 5'd12; bus.req_data[0] = 32'h0C0C_0C0C;
    cyc();
    cyc();
    cyc();
    cyc();

    // reset in the middle of a write drops it asynchronously
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd20;
    cyc();
    bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.issue_rd = '0;
    bus.req_valid[1] = 1'b1; bus.req_rd[1] = 5'd20; bus.req_data[1] = 32'hCAFE_F00D;
    cyc();
    #2;
    chk("pre_rst_we3", bus.we3, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_we3", bus.we3, 0);
    chk("async_rst_err", bus.wb_err, 0);
    chk("async_rst_ready", bus.req_ready, 0);
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.issue_valid = 1'b1; bus.rs1 = 5'd20;
    cyc();
    bus.issue_valid = 1'b0; bus.rs1 = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
